comparador_serial_izq_der: RTL

- Bit-serial magnitude comparator for two N-bit unsigned words.
- Scans from MSB to LSB (left to right), one bit per clock. This is the opposite direction to the existing right-to-left ripple cell chain.
- Stops at the first differing bit and reports greater / equal / less with a start/done handshake.
- Sits in the left-to-right model as the sequential counterpart of the structural cell array.

---
 rtl/comparador_pkg.sv | 15 +
 rtl/celda_comparadora_izq_der.sv | 13 +
 rtl/comparador_serial_izq_der.sv | 104 ++++++++++
 3 files changed

// File: rtl/comparador_pkg.sv
// Shared constants for the left-to-right serial comparator: FSM state codes
// and the one-hot {mayor, igual, menor} result encodings.
package comparador_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPARA = 2'd1;
   localparam logic [1:0] FIN     = 2'd2;

   // Result vector ordering is {mayor, igual, menor}.
   localparam logic [2:0] RES_NINGUNO = 3'b000;
   localparam logic [2:0] RES_MAYOR   = 3'b100;
   localparam logic [2:0] RES_IGUAL   = 3'b010;
   localparam logic [2:0] RES_MENOR   = 3'b001;

endpackage

// File: rtl/celda_comparadora_izq_der.sv
// Combinational single-bit comparison cell: flags a difference and whether
// operand a holds the larger bit at this position.
module celda_comparadora_izq_der (
   input  logic a,
   input  logic b,
   output logic dif,
   output logic a_mayor
);

   assign dif     = a ^ b;
   assign a_mayor = a & ~b;

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Bit-serial unsigned magnitude comparator scanning MSB to LSB, one bit per
// clock, stopping at the first differing position.
module comparador_serial_izq_der
   import comparador_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  A,
   input  logic [N-1:0]  B,
   output logic          busy,
   output logic          done,
   output logic          mayor,
   output logic          igual,
   output logic          menor,
   output logic [CW-1:0] bits_comparados
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [1:0]    estado_q, estado_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [2:0]    res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic bit_a, bit_b, dif, a_mayor;

   assign bit_a = a_q[idx_q];
   assign bit_b = b_q[idx_q];

   celda_comparadora_izq_der u_celda (
      .a       (bit_a),
      .b       (bit_b),
      .dif     (dif),
      .a_mayor (a_mayor)
   );

   always_comb begin
      estado_d = estado_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      case (estado_q)
         IDLE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               idx_d    = IW'(N - 1);
               res_d    = RES_NINGUNO;
               cnt_d    = '0;
               estado_d = COMPARA;
            end
         end
         COMPARA: begin
            cnt_d = cnt_q + CW'(1);
            if (dif) begin
               res_d    = a_mayor ? RES_MAYOR : RES_MENOR;
               estado_d = FIN;
            end else if (idx_q == '0) begin
               // Reaching bit 0 without a difference ends the scan, so idx never wraps.
               res_d    = RES_IGUAL;
               estado_d = FIN;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         FIN:     estado_d = IDLE;
         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         res_q    <= RES_NINGUNO;
         cnt_q    <= '0;
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy            = (estado_q == COMPARA) || (estado_q == FIN);
   assign done            = (estado_q == FIN);
   assign mayor           = res_q[2];
   assign igual           = res_q[1];
   assign menor           = res_q[0];
   assign bits_comparados = cnt_q;

endmodule
